// File: rtl/rv_mon_pkg.sv
// Shared types and helpers for the riscv-tests completion monitor.
package rv_mon_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    PASS = 3'd2,
    FAIL = 3'd3,
    TMO  = 3'd4
  } hart_state_e;

  // riscv-tests leave gp == 1 on success, (testnum << 1) | 1 on failure
  localparam int unsigned GP_PASS  = 1;
  localparam int unsigned HOLD_W   = 4;
  localparam int unsigned MAX_HART = 8;

  // LSB of hart idx's field in a flat bus of width-bit fields
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rv_mon_hart.sv
// Per-hart completion FSM: END_PC hold counter, timeout counter, failure capture.
// With RV_MON_CYCLES_EN defined, also latches the timeout count at the verdict.
//
//   state | meaning
//   IDLE  | not armed; waits for start
//   RUN   | test running; watching retirements and timeout
//   PASS  | gp == 1 sampled after HOLD retirements at END_PC
//   FAIL  | other gp value sampled; testnum captured
//   TMO   | no verdict within TIMEOUT cycles
module rv_mon_hart
  import rv_mon_pkg::*;
#(
  parameter int unsigned    XLEN    = 32,
  parameter logic [XLEN-1:0] END_PC = XLEN'('h44),
  parameter int unsigned    HOLD    = 2,
  parameter int unsigned    TIMEOUT = 5000,
  parameter int unsigned    CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic [XLEN-1:0] gp_val,
  output logic            hart_done,
  output logic            hart_pass,
  output logic [XLEN-2:0] fail_testnum
`ifdef RV_MON_CYCLES_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  hart_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [XLEN-2:0]   testnum_q, testnum_d;

  logic              end_hit;
  logic [HOLD_W-1:0] hold_inc;

  assign end_hit  = ret_valid && (ret_pc == END_PC);
  assign hold_inc = hold_cnt_q + HOLD_W'(1);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    testnum_d  = testnum_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          hold_cnt_d = '0;
          tmo_cnt_d  = '0;
          testnum_d  = '0;
        end
      end
      RUN: begin
        if (start) begin
          hold_cnt_d = '0;
          tmo_cnt_d  = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          if (ret_valid) hold_cnt_d = end_hit ? hold_inc : '0;
          // the END_PC verdict outranks a timeout landing in the same cycle
          if (end_hit && (hold_inc == HOLD_W'(HOLD))) begin
            if (gp_val == XLEN'(GP_PASS)) begin
              state_d = PASS;
            end else begin
              state_d   = FAIL;
              testnum_d = gp_val[XLEN-1:1];
            end
          end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = TMO;
            testnum_d = '0;
          end
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      tmo_cnt_d  = '0;
      testnum_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      testnum_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      testnum_q  <= testnum_d;
    end
  end

  assign hart_done    = (state_q == PASS) || (state_q == FAIL) || (state_q == TMO);
  assign hart_pass    = (state_q == PASS);
  assign fail_testnum = testnum_q;

`ifdef RV_MON_CYCLES_EN
  logic [CNT_W-1:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (clear) cycles_d = '0;
    else if ((state_q == RUN) && !start && (state_d != RUN)) cycles_d = tmo_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) cycles_q <= '0;
    else      cycles_q <= cycles_d;
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: rtl/rv_test_monitor.sv
// Multi-hart riscv-tests completion monitor: one rv_mon_hart per hart plus sticky aggregation.
// RV_MON_CYCLES_EN adds the per-hart 'cycles' output.
module rv_test_monitor
  import rv_mon_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     NHART   = 1,
  parameter logic [XLEN-1:0] END_PC  = XLEN'('h44),
  parameter int unsigned     HOLD    = 2,
  parameter int unsigned     TIMEOUT = 5000,
  parameter int unsigned     CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [NHART-1:0]      ret_valid,
  input  logic [NHART*XLEN-1:0] ret_pc,
  input  logic [NHART*XLEN-1:0] gp_val,
  output logic [NHART-1:0]      hart_done,
  output logic [NHART-1:0]      hart_pass,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            fail_hart,
  output logic [XLEN-2:0]       fail_testnum
`ifdef RV_MON_CYCLES_EN
  ,
  output logic [NHART*CNT_W-1:0] cycles
`endif
);

  logic [XLEN-2:0] hart_testnum [NHART];

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    rv_mon_hart #(
      .XLEN    (XLEN),
      .END_PC  (END_PC),
      .HOLD    (HOLD),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_hart (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .clear        (clear),
      .ret_valid    (ret_valid[h]),
      .ret_pc       (ret_pc[field_lsb(h, XLEN) +: XLEN]),
      .gp_val       (gp_val[field_lsb(h, XLEN) +: XLEN]),
      .hart_done    (hart_done[h]),
      .hart_pass    (hart_pass[h]),
      .fail_testnum (hart_testnum[h])
`ifdef RV_MON_CYCLES_EN
      ,
      .cycles       (cycles[field_lsb(h, CNT_W) +: CNT_W])
`endif
    );
  end

  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [2:0]      fail_hart_q, fail_hart_d;
  logic [XLEN-2:0] fail_testnum_q, fail_testnum_d;
  logic            all_done;

  assign all_done = &hart_done;

  always_comb begin
    done_d         = all_done;
    pass_d         = all_done && (&hart_pass);
    fail_hart_d    = '0;
    fail_testnum_d = '0;
    if (all_done && done_q) begin
      // first reported failure sticks for as long as done stays up
      fail_hart_d    = fail_hart_q;
      fail_testnum_d = fail_testnum_q;
    end else if (all_done) begin
      for (int i = int'(NHART) - 1; i >= 0; i--) begin
        if (!hart_pass[i]) begin
          fail_hart_d    = 3'(i);
          fail_testnum_d = hart_testnum[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_hart_q    <= '0;
      fail_testnum_q <= '0;
    end else begin
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_hart_q    <= fail_hart_d;
      fail_testnum_q <= fail_testnum_d;
    end
  end

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_hart    = fail_hart_q;
  assign fail_testnum = fail_testnum_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Bench for rv_test_monitor: a 1-hart instance (TIMEOUT=20) and a 4-hart instance (TIMEOUT=60).
// Expected outputs are queued when each cycle's stimulus is driven and checked after the edge.
module tb_rv_test_monitor;

  logic clk;
  logic rst;

  logic        start1, clear1, rv1;
  logic [31:0] pc1, gp1;
  logic        hd1, hp1, d1, p1;
  logic [2:0]  fh1;
  logic [30:0] tn1;

  logic         start4, clear4;
  logic [3:0]   rv4;
  logic [127:0] pc4, gp4;
  logic [3:0]   hd4, hp4;
  logic         d4, p4;
  logic [2:0]   fh4;
  logic [30:0]  tn4;

`ifdef RV_MON_CYCLES_EN
  logic [15:0] cyc1;
  logic [63:0] cyc4;
`endif

  rv_test_monitor #(
    .XLEN(32), .NHART(1), .END_PC(32'h44), .HOLD(2), .TIMEOUT(20), .CNT_W(16)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1), .clear(clear1),
    .ret_valid(rv1), .ret_pc(pc1), .gp_val(gp1),
    .hart_done(hd1), .hart_pass(hp1), .done(d1), .pass(p1),
    .fail_hart(fh1), .fail_testnum(tn1)
`ifdef RV_MON_CYCLES_EN
    , .cycles(cyc1)
`endif
  );

  rv_test_monitor #(
    .XLEN(32), .NHART(4), .END_PC(32'h44), .HOLD(2), .TIMEOUT(60), .CNT_W(16)
  ) u4 (
    .clk(clk), .rst(rst), .start(start4), .clear(clear4),
    .ret_valid(rv4), .ret_pc(pc4), .gp_val(gp4),
    .hart_done(hd4), .hart_pass(hp4), .done(d4), .pass(p4),
    .fail_hart(fh4), .fail_testnum(tn4)
`ifdef RV_MON_CYCLES_EN
    , .cycles(cyc4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        r, s, c, v;
    logic [31:0] pc, gp;
    logic        hd, hp, d, p;
    logic [2:0]  fh;
    logic [30:0] tn;
  } vec_t;

  typedef struct {
    int          sel;
    logic [3:0]  hd, hp;
    logic        d, p;
    logic [2:0]  fh;
    logic [30:0] tn;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input logic r, s, c, v, input logic [31:0] pc, gp,
                              input logic hd, hp, d, p, input logic [2:0] fh,
                              input logic [30:0] tn);
    vec_t x;
    x.r = r; x.s = s; x.c = c; x.v = v; x.pc = pc; x.gp = gp;
    x.hd = hd; x.hp = hp; x.d = d; x.p = p; x.fh = fh; x.tn = tn;
    return x;
  endfunction

  task automatic step1(input vec_t x, input string nm);
    exp_t e;
    @(negedge clk);
    rst = x.r; start1 = x.s; clear1 = x.c; rv1 = x.v; pc1 = x.pc; gp1 = x.gp;
    start4 = 1'b0; clear4 = 1'b0; rv4 = '0;
    e.sel = 0; e.hd = {3'b000, x.hd}; e.hp = {3'b000, x.hp};
    e.d = x.d; e.p = x.p; e.fh = x.fh; e.tn = x.tn; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic step4(input logic s, input logic [3:0] v, input logic [3:0] ehd, ehp,
                       input logic ed, ep, input logic [2:0] efh, input logic [30:0] etn,
                       input string nm);
    exp_t e;
    @(negedge clk);
    rst = 1'b1; start4 = s; clear4 = 1'b0; rv4 = v;
    start1 = 1'b0; clear1 = 1'b0; rv1 = 1'b0;
    e.sel = 1; e.hd = ehd; e.hp = ehp; e.d = ed; e.p = ep; e.fh = efh; e.tn = etn; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // checker: consumes one expectation per edge
  initial begin
    exp_t        e;
    logic [3:0]  ahd, ahp;
    logic        ad, ap;
    logic [2:0]  afh;
    logic [30:0] atn;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.sel == 0) begin
          ahd = {3'b000, hd1}; ahp = {3'b000, hp1}; ad = d1; ap = p1; afh = fh1; atn = tn1;
        end else begin
          ahd = hd4; ahp = hp4; ad = d4; ap = p4; afh = fh4; atn = tn4;
        end
        compared++;
        if (ahd !== e.hd || ahp !== e.hp || ad !== e.d || ap !== e.p ||
            afh !== e.fh || atn !== e.tn) begin
          mismatched++;
          $display("FAIL %s: got hart_done=%h hart_pass=%h done=%b pass=%b fail_hart=%0d testnum=%0d, expected %h %h %b %b %0d %0d",
                   e.nm, ahd, ahp, ad, ap, afh, atn, e.hd, e.hp, e.d, e.p, e.fh, e.tn);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[$];

  initial begin
    rst = 1'b0; start1 = 1'b0; clear1 = 1'b0; rv1 = 1'b0; pc1 = '0; gp1 = '0;
    start4 = 1'b0; clear4 = 1'b0; rv4 = '0;
    pc4 = {32'h44, 32'h44, 32'h44, 32'h44};
    gp4 = {32'd7, 32'd1, 32'd3, 32'd1};

    //           r  s  c  v  pc     gp       hd hp d  p  fh tn
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0));  // reset
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0));  // scenario 1
    tbl.push_back(mk(1, 0, 0, 1, 32'h40, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'h1,  1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h5,  1, 1, 1, 1, 0, 0));  // sticky
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  32'h0,  0, 0, 1, 1, 0, 0));  // clear; aggregate lags
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0));  // scenario 2
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'hB,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h48, 32'hB,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'hB,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h44, 32'hB,  0, 0, 0, 0, 0, 0));  // no retire: hold kept
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'hB,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'hB,  1, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  32'h0,  0, 0, 1, 0, 0, 5));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0));  // restart in RUN
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h44, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,  1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,  1, 1, 1, 1, 0, 0));  // start ignored when done
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0));  // rst beats start
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0));  // clear beats start
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0));  // lone start arms
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h44, 32'h1,  1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,  1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,  32'h0,  0, 0, 1, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step1(tbl[i], $sformatf("tbl[%0d]", i));

    // timeout: no retirements, verdict on the 20th edge after start
    step1(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tmo_start");
    for (int k = 1; k <= 20; k++)
      step1(mk(1, 0, 0, 0, 0, 0, (k == 20), 0, 0, 0, 0, 0), $sformatf("tmo_k%0d", k));
    step1(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), "tmo_done");
    step1(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), "tmo_clear");

    // verdict and timeout on the same cycle: verdict wins
    step1(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "race_start");
    for (int k = 1; k <= 20; k++)
      step1(mk(1, 0, 0, (k >= 19), 32'h44, 32'h1, (k == 20), (k == 20), 0, 0, 0, 0),
            $sformatf("race_k%0d", k));
    step1(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0), "race_done");
    step1(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0), "race_clear");

    // scenario 1 finishing 10 cycles after start
    step1(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "cyc_start");
    for (int k = 1; k <= 10; k++)
      step1(mk(1, 0, 0, (k >= 8), (k == 8) ? 32'h40 : 32'h44, 32'h1, (k == 10), (k == 10), 0, 0, 0, 0),
            $sformatf("cyc_k%0d", k));
`ifdef RV_MON_CYCLES_EN
    compared++;
    if (cyc1 !== 16'd9) begin
      mismatched++;
      $display("FAIL cycles_at_verdict: got %0d expected 9", cyc1);
    end
`endif
    for (int k = 11; k <= 13; k++)
      step1(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0), $sformatf("cyc_k%0d", k));
`ifdef RV_MON_CYCLES_EN
    compared++;
    if (cyc1 !== 16'd9) begin
      mismatched++;
      $display("FAIL cycles_held: got %0d expected 9", cyc1);
    end
`endif
    step1(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0), "cyc_clear");

    // four harts: 0 and 2 pass, 3 fails (gp=7), then 1 fails (gp=3)
    step4(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, "h4_start");
    step4(0, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 0, "h4_a");
    step4(0, 4'b0101, 4'b0101, 4'b0101, 0, 0, 0, 0, "h4_b");
    step4(0, 4'b1000, 4'b0101, 4'b0101, 0, 0, 0, 0, "h4_c");
    step4(0, 4'b1000, 4'b1101, 4'b0101, 0, 0, 0, 0, "h4_d");
    step4(0, 4'b0010, 4'b1101, 4'b0101, 0, 0, 0, 0, "h4_e");
    step4(0, 4'b0010, 4'b1111, 4'b0101, 0, 0, 0, 0, "h4_f");
    step4(0, 4'b0000, 4'b1111, 4'b0101, 1, 0, 1, 1, "h4_g");
    step4(0, 4'b0000, 4'b1111, 4'b0101, 1, 0, 1, 1, "h4_h");

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv_test_monitor.md
Name: rv_test_monitor

Overview:
- Synthesizable completion monitor for riscv-tests programs running on one or more cores (harts).
- Replaces ad-hoc bench checks of "PC reached end address, gp == 1".
- Watches each hart's retired PC and gp (x3) value, and decides pass, fail or timeout per hart.
- Aggregates the per-hart results into one sticky verdict that benches and FPGA tops can read.

Parameters:
- XLEN, 32: width of PC and register values.
- NHART, 1: number of monitored harts (1..8).
- END_PC, 32'h44: PC whose retirement marks end of test.
- HOLD, 2: consecutive retirements at END_PC required before sampling gp (1..15).
- TIMEOUT, 5000: cycles after start with no verdict before the hart is declared timed out.
- CNT_W, 16: width of timeout/cycle counters; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  one-cycle pulse; arms all harts.
- clear  in  1  returns all harts to IDLE without a reset.
- ret_valid  in  NHART  per-hart retire strobe.
- ret_pc  in  NHART*XLEN  retired PC; hart h occupies bits [h*XLEN +: XLEN].
- gp_val  in  NHART*XLEN  current x3 value per hart.
- hart_done  out  NHART  hart h reached a terminal state.
- hart_pass  out  NHART  hart h passed.
- done  out  1  all harts terminal.
- pass  out  1  done and every hart passed.
- fail_hart  out  3  lowest-index hart that failed or timed out; valid when done && !pass.
- fail_testnum  out  XLEN-1  gp_val>>1 captured at fail for fail_hart; 0 for a timeout.

Behaviour:
- Reset (rst == 0 at a posedge):
  - every hart enters IDLE; all outputs go to 0; counters clear.
  - rst has priority over start and clear.
- Per-hart FSM:
  - IDLE -> RUN on start.
  - RUN -> PASS, FAIL or TMO, as defined below.
  - PASS, FAIL and TMO are sticky until clear or rst.
  - clear -> IDLE from any state. clear has priority over start in the same cycle.
  - start while in RUN restarts the hart: counters clear, state stays RUN.
  - start while in a terminal state is ignored.
- RUN detail:
  - hold_cnt increments on ret_valid && ret_pc == END_PC.
  - hold_cnt resets to 0 on ret_valid with any other PC.
  - cycles without ret_valid leave hold_cnt unchanged.
  - When hold_cnt reaches HOLD, sample gp_val in that same cycle:
    - gp_val == 1 -> PASS.
    - any other value -> FAIL; store gp_val>>1.
- Timeout:
  - tmo_cnt increments every RUN cycle.
  - When it equals TIMEOUT-1 with no verdict, the next state is TMO.
  - If the END_PC verdict and the timeout fire in the same cycle, the verdict wins.
- Latency: hart_done/hart_pass assert on the clock edge after the qualifying retirement (registered outputs).
- done, pass, fail_hart and fail_testnum are registered from the hart states, so they lag hart_done by 1 cycle.
- fail_hart priority: lowest index among harts in FAIL or TMO. Later failures do not change it once done is set.
- Harts left in IDLE after start never complete, so done stays low. Benches must arm all harts.

Optional Feature:
- Macro RV_MON_CYCLES_EN.
- Defined:
  - adds output cycles (NHART*CNT_W).
  - each field holds tmo_cnt latched at the hart's terminal transition.
  - it holds until clear/rst.
- Undefined: the port is absent and no latch registers are built.

Decomposition:
- Package rv_mon_pkg holds:
  - hart state enum: IDLE, RUN, PASS, FAIL, TMO.
  - GP_PASS constant (1).
  - helper function to slice a hart's field from a flat bus.
- One sub-module: rv_mon_hart.
  - contains per-hart FSM, hold/timeout counters and failure capture.
  - instantiated NHART times via generate.
- The top holds only the aggregation registers.

Test Plan:
1. NHART=1:
   - start, then retire PCs 0x40, 0x44, 0x44 with gp=1.
   - -> hart_pass=1 on the edge after the 2nd 0x44; done=pass=1 one cycle later.
2. NHART=1:
   - retire 0x44, 0x48, 0x44 (hold broken), then a further 0x44 with gp=0xB.
   - -> FAIL only after the second consecutive 0x44; fail_testnum=5, fail_hart=0.
3. NHART=1, TIMEOUT=20:
   - start, no retirements.
   - -> hart_done on cycle 20 after start; pass=0; fail_testnum=0.
4. NHART=4:
   - harts 0 and 2 pass, hart 3 fails with gp=7, then hart 1 fails with gp=3.
   - -> done after the last of them; fail_hart=1; fail_testnum=1.
5. Control priority:
   - drive rst=0 mid-RUN, then start, and assert clear together with start.
   - -> all outputs 0, harts stay IDLE; a subsequent lone start arms normally.
6. RV_MON_CYCLES_EN defined, scenario 1 run 10 cycles after start.
   - -> cycles field equals the tmo_cnt value at the verdict and stays constant afterwards.
